sync_debounce: RTL and testbench

//  Multi-channel input conditioner: per-channel N-flop synchronizer followed by a

---
 rtl/sync_debounce.sv | 66 ++++++
 tb/tb_sync_debounce.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: N-flop synchronizer, counter debouncer and
// registered rise/fall edge pulses for raw asynchronous pins.
module sync_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 8,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] accept;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
        end else begin
            sync_ff[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
        end
    end

    assign sync_val = sync_ff[SYNC_STAGES-1];
    assign mismatch = sync_val ^ stable_out;

    // a channel flips once it has disagreed with its stable level for the full window
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = mismatch[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            stable_out <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            changed    <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!mismatch[i] || accept[i]) cnt[i] <= '0;
                else                           cnt[i] <= cnt[i] + CW'(1);
            end
            stable_out <= stable_out ^ accept;
            rise_pulse <= accept & sync_val;
            fall_pulse <= accept & ~sync_val;
            changed    <= |accept;
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed scenarios plus randomized pin activity, with
// a window-based reference model checked every cycle on two debounce depths.
module tb_sync_debounce;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] async_in = 4'b0000;

    logic [3:0] stable_0, rise_0, fall_0;
    logic       changed_0;
    logic [3:0] stable_1, rise_1, fall_1;
    logic       changed_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    sync_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RESET_VAL(4'b0000)) dut_0 (
        .clk(clk), .reset(reset), .async_in(async_in),
        .stable_out(stable_0), .rise_pulse(rise_0), .fall_pulse(fall_0), .changed(changed_0)
    );

    sync_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'b0000)) dut_1 (
        .clk(clk), .reset(reset), .async_in(async_in),
        .stable_out(stable_1), .rise_pulse(rise_1), .fall_pulse(fall_1), .changed(changed_1)
    );

    // Reference: a level is accepted when the last DC synchronized samples since
    // reset or the previous acceptance all disagreed with it.
    logic [3:0] m_chain  [2][2];
    logic [3:0] m_stable [2];
    logic [3:0] m_rise   [2];
    logic [3:0] m_fall   [2];
    logic [7:0] m_win    [2][4];
    int         m_fill   [2][4];

    function automatic int dc_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_chain[k][0] = 4'b0000;
                m_chain[k][1] = 4'b0000;
                m_stable[k]   = 4'b0000;
                m_rise[k]     = 4'b0000;
                m_fall[k]     = 4'b0000;
                for (int c = 0; c < 4; c++) begin
                    m_win[k][c]  = 8'h00;
                    m_fill[k][c] = 0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] sv;
                logic [7:0] mask;
                sv = m_chain[k][1];
                mask = 8'((1 << dc_of(k)) - 1);
                m_rise[k] = 4'b0000;
                m_fall[k] = 4'b0000;
                for (int c = 0; c < 4; c++) begin
                    m_win[k][c] = {m_win[k][c][6:0], sv[c] != m_stable[k][c]};
                    if (m_fill[k][c] < 8) m_fill[k][c]++;
                    if (m_fill[k][c] >= dc_of(k) && (m_win[k][c] & mask) == mask) begin
                        m_stable[k][c] = sv[c];
                        if (sv[c]) m_rise[k][c] = 1'b1;
                        else       m_fall[k][c] = 1'b1;
                        m_win[k][c]  = 8'h00;
                        m_fill[k][c] = 0;
                    end
                end
                m_chain[k][1] = m_chain[k][0];
                m_chain[k][0] = async_in;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("stable_0",  32'(stable_0),  32'(m_stable[0]));
        check("rise_0",    32'(rise_0),    32'(m_rise[0]));
        check("fall_0",    32'(fall_0),    32'(m_fall[0]));
        check("changed_0", 32'(changed_0), 32'(|(m_rise[0] | m_fall[0])));
        check("stable_1",  32'(stable_1),  32'(m_stable[1]));
        check("rise_1",    32'(rise_1),    32'(m_rise[1]));
        check("fall_1",    32'(fall_1),    32'(m_fall[1]));
        check("changed_1", 32'(changed_1), 32'(|(m_rise[1] | m_fall[1])));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        // 1: reset held with pins at 1010, then release
        async_in = 4'b1010;
        reset = 1'b0;
        #1;
        check("rst_stable", 32'(stable_0), 32'h0);
        check("rst_pulse",  32'(rise_0 | fall_0), 32'h0);
        cyc(2);
        check("rst_hold", 32'(stable_0), 32'h0);
        reset = 1'b1;
        cyc(9);
        check("s1_pre", 32'(stable_0), 32'h0);
        cyc(1);
        check("s1_stable", 32'(stable_0), 32'b1010);
        check("s1_rise",   32'(rise_0),   32'b1010);
        async_in = 4'b0000;
        cyc(12);

        // 2: full step up and down
        async_in = 4'b1111;
        cyc(2);
        check("s2_dc1_pre", 32'(stable_1), 32'h0);
        cyc(1);
        check("s2_dc1_edge3", 32'(stable_1), 32'b1111);
        check("s2_dc1_rise",  32'(rise_1),   32'b1111);
        cyc(6);
        check("s2_edge9", 32'(stable_0), 32'h0);
        cyc(1);
        check("s2_edge10",   32'(stable_0),  32'b1111);
        check("s2_rise",     32'(rise_0),    32'b1111);
        check("s2_changed",  32'(changed_0), 32'h1);
        cyc(1);
        check("s2_rise_end", 32'(rise_0), 32'h0);
        async_in = 4'b0000;
        cyc(10);
        check("s2_fall",     32'(fall_0),   32'b1111);
        check("s2_fall_lvl", 32'(stable_0), 32'h0);
        cyc(3);

        // 3: short glitch on ch0
        async_in = 4'b0001;
        cyc(5);
        async_in = 4'b0000;
        cyc(15);
        check("s3_glitch", 32'(stable_0), 32'h0);

        // 4: bouncing ch1 then held high
        for (int t = 0; t < 4; t++) begin
            async_in = (t % 2 == 0) ? 4'b0010 : 4'b0000;
            cyc(3);
        end
        async_in = 4'b0010;
        cyc(9);
        check("s4_pre", 32'(stable_0), 32'h0);
        cyc(1);
        check("s4_rise",   32'(rise_0),   32'b0010);
        check("s4_stable", 32'(stable_0), 32'b0010);

        // 5: independent channels
        async_in = 4'b1000;
        cyc(12);
        async_in = 4'b1001;
        cyc(3);
        async_in = 4'b0001;
        cyc(7);
        check("s5_rise", 32'(rise_0), 32'b0001);
        cyc(3);
        check("s5_fall", 32'(fall_0), 32'b1000);

        // 6: reset during a pending rise
        async_in = 4'b0000;
        cyc(12);
        async_in = 4'b1111;
        cyc(6);
        reset = 1'b0;
        #1;
        check("s6_rst_s0", 32'(stable_0), 32'h0);
        check("s6_rst_s1", 32'(stable_1), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc(9);
        check("s6_pre", 32'(stable_0), 32'h0);
        cyc(1);
        check("s6_edge10", 32'(stable_0), 32'b1111);

        // randomized activity with occasional asynchronous resets
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 7) == 0) async_in[c] = ~async_in[c];
            end
            if ($urandom_range(0, 149) == 0) begin
                #($urandom_range(2, 8));
                reset = 1'b0;
                #1;
                check_all();
                @(negedge clk);
                reset = 1'b1;
            end
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
